// File: rtl/sim_pkg.sv
// Shared definitions for the simulation stimulus controller: TX state
// encoding, UART frame width and default parameter values.
// Latency: n/a. Backpressure: n/a.
package sim_pkg;

    localparam int unsigned UART_DATA_BITS     = 8;

    localparam int unsigned DEF_RST_CYCLES     = 25;
    localparam int unsigned DEF_BAUD_DIV       = 16;
    localparam int unsigned DEF_DEPTH          = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 150000000;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sim_stim_ctrl_if.sv
// Stimulus controller bus: byte push handshake plus target-facing outputs.
// Latency: n/a (wires only).
// Backpressure: push_valid/push_ready; a byte moves when both are high.
// Ports: push_valid/push_data/push_ready (byte handshake), dut_rst, rx,
//        busy, timeout, tx_count (status toward the bench / target).
interface sim_stim_ctrl_if;
    import sim_pkg::*;

    logic                      push_valid;
    logic [UART_DATA_BITS-1:0] push_data;
    logic                      push_ready;
    logic                      dut_rst;
    logic                      rx;
    logic                      busy;
    logic                      timeout;
    logic [31:0]               tx_count;

    // master: the side that produces bytes and observes status
    modport master (
        output push_valid, push_data,
        input  push_ready, dut_rst, rx, busy, timeout, tx_count
    );

    // slave: the stimulus controller itself
    modport slave (
        input  push_valid, push_data,
        output push_ready, dut_rst, rx, busy, timeout, tx_count
    );

endinterface

// File: rtl/sim_byte_fifo.sv
// Generic synchronous FIFO with occupancy count output.
// Latency: written entry visible at rd_dat the cycle after the write edge.
// Backpressure: wr_rdy low when full; a write while full is dropped.
// Ports: clk, rst_n (sync, active-low), wr_vld/wr_rdy/wr_dat, rd_vld/rd_rdy/rd_dat, count.
module sim_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign wr_rdy = (cnt_q != FULL_CNT);
    assign rd_vld = (cnt_q != '0);
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_rdy && rd_vld;
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + ONE_PTR;
        if (do_rd) rd_ptr_d = rd_ptr_q + ONE_PTR;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + ONE_CNT;
            2'b01:   cnt_d = cnt_q - ONE_CNT;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/sim_stim_ctrl.sv
// Stimulus controller: target reset sequencer, byte FIFO feeding a UART TX
// line (start, 8 data LSB first, stop), and a sticky cycle watchdog.
// Latency: byte pushed at edge N (target out of reset, TX idle) starts its
//          start bit after edge N+1; one idle cycle separates queued frames.
// Backpressure: push_ready = FIFO not full; refused pushes are dropped.
// Ports: clk, rst_n (sync, active-low), bus (sim_stim_ctrl_if.slave).
module sim_stim_ctrl
    import sim_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned BAUD_DIV       = DEF_BAUD_DIV,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    sim_stim_ctrl_if.slave bus
);
    localparam int unsigned   CW        = $clog2(DEPTH) + 1;
    localparam int unsigned   BW        = $clog2(UART_DATA_BITS);
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    tx_state_e                 state_q, state_d;
    logic [31:0]               rst_cnt_q, rst_cnt_d;
    logic                      dut_rst_q, dut_rst_d;
    logic [15:0]               baud_cnt_q, baud_cnt_d;
    logic [BW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [31:0]               tx_count_q, tx_count_d;
    logic [31:0]               wd_cnt_q, wd_cnt_d;
    logic                      timeout_q, timeout_d;

    logic                      fifo_rd_vld;
    logic [UART_DATA_BITS-1:0] fifo_rd_dat;
    logic [CW-1:0]             fifo_count;
    logic                      pop;
    logic                      baud_done;
    logic                      rx_o;

    sim_byte_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (bus.push_valid),
        .wr_rdy (bus.push_ready),
        .wr_dat (bus.push_data),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_rd_dat),
        .count  (fifo_count)
    );

    assign baud_done = (baud_cnt_q == BAUD_LAST);
    // Head byte is taken only from IDLE with the target out of reset.
    assign pop       = (state_q == TX_IDLE) && fifo_rd_vld && !dut_rst_q;

    // Reset sequencer: counts cycles with rst_n high, then releases for good.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        dut_rst_d = dut_rst_q;
        if (dut_rst_q) begin
            if (rst_cnt_q + 32'd1 >= RST_CYCLES) dut_rst_d = 1'b0;
            else                                 rst_cnt_d = rst_cnt_q + 32'd1;
        end
    end

    // Watchdog: runs once the target is released; freezes when it fires.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (TIMEOUT_CYCLES != 0 && !dut_rst_q && !timeout_q) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
            if (wd_cnt_q + 32'd1 == TIMEOUT_CYCLES) timeout_d = 1'b1;
        end
    end

    // TX FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (pop)                                  state_d = TX_START;
            TX_START: if (baud_done)                            state_d = TX_DATA;
            TX_DATA:  if (baud_done && bit_idx_q == BIT_LAST)   state_d = TX_STOP;
            TX_STOP:  if (baud_done)                            state_d = TX_IDLE;
            default:                                            state_d = TX_IDLE;
        endcase
    end

    // TX datapath: baud timer, bit index, shift register, frame counter.
    always_comb begin
        baud_cnt_d = baud_cnt_q + 16'd1;
        if (state_q == TX_IDLE || baud_done) baud_cnt_d = '0;
        bit_idx_d = bit_idx_q;
        if (state_q == TX_START)                 bit_idx_d = '0;
        else if (state_q == TX_DATA && baud_done) bit_idx_d = bit_idx_q + BIT_ONE;
        shift_d = pop ? fifo_rd_dat : shift_q;
        tx_count_d = tx_count_q;
        if (state_q == TX_STOP && baud_done) tx_count_d = tx_count_q + 32'd1;
    end

    // TX FSM outputs.
    always_comb begin
        rx_o = 1'b1;
        case (state_q)
            TX_START: rx_o = 1'b0;
            TX_DATA:  rx_o = shift_q[bit_idx_q];
            default:  rx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= TX_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt_q  <= '0;
            dut_rst_q  <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_count_q <= '0;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            dut_rst_q  <= dut_rst_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_count_q <= tx_count_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.rx       = rx_o;
    assign bus.dut_rst  = dut_rst_q;
    assign bus.timeout  = timeout_q;
    assign bus.tx_count = tx_count_q;
    assign bus.busy     = (fifo_count != '0) || (state_q != TX_IDLE);

endmodule

// File: tb/tb_sim_stim_ctrl.sv
// Bench for sim_stim_ctrl: two instances (DEPTH=4 with a 100-cycle watchdog,
// and DEPTH=16 with the watchdog disabled) exercised by directed and random tests.
// Expected line levels come from the UART frame rule, not from the RTL.
module tb_sim_stim_ctrl;
    import sim_pkg::*;

    localparam int BAUD    = 16;
    localparam int RSTC    = 25;
    localparam int FRAME   = 10 * BAUD;
    localparam int A_DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } push_t;

    logic clk = 1'b0;
    logic rst_na;
    logic rst_nb;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // random-test shared state
    push_t exp_q[$];
    int    r_seq_err, r_wave_err, r_to_err, r_frames;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sim_stim_ctrl_if bus_a ();
    sim_stim_ctrl_if bus_b ();

    sim_stim_ctrl #(.RST_CYCLES(RSTC), .BAUD_DIV(BAUD), .DEPTH(A_DEPTH), .TIMEOUT_CYCLES(100)) u_dut_a (
        .clk (clk), .rst_n (rst_na), .bus (bus_a)
    );

    sim_stim_ctrl #(.RST_CYCLES(RSTC), .BAUD_DIV(BAUD), .DEPTH(16), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk (clk), .rst_n (rst_nb), .bus (bus_b)
    );

    // Line level k cycles into a frame: start bit, data LSB first, stop bit.
    function automatic logic frame_level(input logic [7:0] b, input int k);
        if (k < BAUD)     return 1'b0;
        if (k < 9 * BAUD) return b[3'((k - BAUD) / BAUD)];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        bit rx_ok;
        rst_na = 1'b0;
        repeat (3) step();
        n_tests += 6;
        if (bus_a.dut_rst !== 1'b1)     begin n_fail++; $display("FAIL rst_dut_rst: got %b want 1", bus_a.dut_rst); end
        if (bus_a.rx !== 1'b1)          begin n_fail++; $display("FAIL rst_rx: got %b want 1", bus_a.rx); end
        if (bus_a.timeout !== 1'b0)     begin n_fail++; $display("FAIL rst_timeout: got %b want 0", bus_a.timeout); end
        if (bus_a.tx_count !== 32'd0)   begin n_fail++; $display("FAIL rst_tx_count: got %0d want 0", bus_a.tx_count); end
        if (bus_a.busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_a.busy); end
        if (bus_a.push_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_push_ready: got %b want 1", bus_a.push_ready); end
        rst_na = 1'b1;
        n = 0;
        rx_ok = 1'b1;
        while (bus_a.dut_rst === 1'b1 && n < 200) begin
            if (bus_a.rx !== 1'b1) rx_ok = 1'b0;
            n++;
            step();
        end
        n_tests += 2;
        if (n != RSTC) begin n_fail++; $display("FAIL rst_release_len: got %0d cycles want %0d", n, RSTC); end
        if (!rx_ok)    begin n_fail++; $display("FAIL rst_release_rx: rx left idle during reset sequence"); end
    endtask

    task automatic test_single_byte();
        int g;
        int errs;
        logic exp;
        rst_nb = 1'b1;
        g = 0;
        while (bus_b.dut_rst === 1'b1 && g < 200) begin step(); g++; end
        n_tests++;
        if (bus_b.dut_rst !== 1'b0) begin n_fail++; $display("FAIL single_release: dut_rst %b want 0", bus_b.dut_rst); end
        bus_b.push_data  = 8'hA5;
        bus_b.push_valid = 1'b1;
        step();
        bus_b.push_valid = 1'b0;
        n_tests++;
        if (bus_b.rx !== 1'b1 || bus_b.busy !== 1'b1)
            begin n_fail++; $display("FAIL single_queued: rx %b busy %b want 1 1", bus_b.rx, bus_b.busy); end
        errs = 0;
        for (int j = 0; j <= FRAME; j++) begin
            step();
            exp = (j < FRAME) ? frame_level(8'hA5, j) : 1'b1;
            if (bus_b.rx !== exp) errs++;
        end
        n_tests += 3;
        if (errs != 0)                 begin n_fail++; $display("FAIL single_wave: %0d wrong rx cycles want 0", errs); end
        if (bus_b.tx_count !== 32'd1)  begin n_fail++; $display("FAIL single_tx_count: got %0d want 1", bus_b.tx_count); end
        if (bus_b.busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy: got %b want 0", bus_b.busy); end
    endtask

    task automatic test_mid_frame_reset();
        int g;
        int n;
        bit rx_ok;
        bus_b.push_data  = 8'($urandom) & 8'hF7;  // bit 3 low so the abort is visible
        bus_b.push_valid = 1'b1;
        step();
        bus_b.push_valid = 1'b0;
        g = 0;
        while (bus_b.rx !== 1'b0 && g < 50) begin step(); g++; end
        n_tests++;
        if (bus_b.rx !== 1'b0) begin n_fail++; $display("FAIL mid_start: start bit not seen, rx %b", bus_b.rx); end
        repeat (BAUD + 3 * BAUD + 5) step();
        n_tests += 2;
        if (bus_b.rx !== 1'b0 || bus_b.busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_bit3: rx %b busy %b want 0 1", bus_b.rx, bus_b.busy); end
        if (bus_b.tx_count !== 32'd1)  begin n_fail++; $display("FAIL mid_pre_count: got %0d want 1", bus_b.tx_count); end
        rst_nb = 1'b0;
        step();
        n_tests += 5;
        if (bus_b.rx !== 1'b1)         begin n_fail++; $display("FAIL mid_rx: got %b want 1", bus_b.rx); end
        if (bus_b.tx_count !== 32'd0)  begin n_fail++; $display("FAIL mid_tx_count: got %0d want 0", bus_b.tx_count); end
        if (bus_b.busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus_b.busy); end
        if (bus_b.dut_rst !== 1'b1)    begin n_fail++; $display("FAIL mid_dut_rst: got %b want 1", bus_b.dut_rst); end
        if (bus_b.timeout !== 1'b0)    begin n_fail++; $display("FAIL mid_timeout: got %b want 0", bus_b.timeout); end
        rst_nb = 1'b1;
        n = 0;
        rx_ok = 1'b1;
        while (bus_b.dut_rst === 1'b1 && n < 200) begin
            if (bus_b.rx !== 1'b1) rx_ok = 1'b0;
            n++;
            step();
        end
        n_tests++;
        if (n != RSTC || !rx_ok) begin n_fail++; $display("FAIL mid_rerun: got %0d cycles rx_ok %0d want %0d 1", n, rx_ok, RSTC); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] q[$];
        logic [7:0] d;
        int   occ;
        int   ready_err;
        int   g;
        int   f, k;
        int   wave_err[5];
        logic exp_rdy, exp;
        rst_na = 1'b0;
        repeat (2) step();
        rst_na = 1'b1;
        occ = 0;
        ready_err = 0;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            exp_rdy = (occ < A_DEPTH);
            if (bus_a.push_ready !== exp_rdy) ready_err++;
            bus_a.push_valid = 1'b1;
            bus_a.push_data  = d;
            if (exp_rdy) begin q.push_back(d); occ++; end
            step();
        end
        bus_a.push_valid = 1'b0;
        n_tests += 4;
        if (ready_err != 0)            begin n_fail++; $display("FAIL full_ready_seq: %0d wrong push_ready cycles want 0", ready_err); end
        if (bus_a.push_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_at_4: got %b want 0", bus_a.push_ready); end
        if (bus_a.dut_rst !== 1'b1)    begin n_fail++; $display("FAIL full_in_reset: dut_rst %b want 1", bus_a.dut_rst); end
        if (bus_a.rx !== 1'b1)         begin n_fail++; $display("FAIL full_hold_tx: rx %b want 1 while in reset", bus_a.rx); end
        g = 0;
        while (bus_a.dut_rst === 1'b1 && g < 200) begin step(); g++; end
        for (int i = 0; i < 5; i++) wave_err[i] = 0;
        for (int m = 0; m <= 650; m++) begin
            f = (m == 0) ? 4 : (m - 1) / (FRAME + 1);
            k = (m == 0) ? 0 : (m - 1) % (FRAME + 1);
            exp = (f < 4 && k < FRAME) ? frame_level(q[f], k) : 1'b1;
            if (bus_a.rx !== exp) wave_err[(f < 4) ? f : 4]++;
            if (m < 650) step();
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (wave_err[i] != 0) begin n_fail++; $display("FAIL full_frame%0d: %0d wrong rx cycles want 0", i, wave_err[i]); end
        end
        n_tests += 2;
        if (bus_a.tx_count !== 32'd4) begin n_fail++; $display("FAIL full_tx_count: got %0d want 4", bus_a.tx_count); end
        if (bus_a.busy !== 1'b0)      begin n_fail++; $display("FAIL full_busy: got %b want 0", bus_a.busy); end
    endtask

    task automatic test_watchdog();
        logic [7:0] d;
        int   g;
        int   first_to;
        int   stuck_err;
        int   wave_err;
        logic exp;
        rst_na = 1'b0;
        repeat (2) step();
        rst_na = 1'b1;
        d = 8'($urandom);
        bus_a.push_data  = d;
        bus_a.push_valid = 1'b1;
        step();
        bus_a.push_valid = 1'b0;
        g = 0;
        while (bus_a.dut_rst === 1'b1 && g < 200) begin step(); g++; end
        first_to = -1;
        stuck_err = 0;
        wave_err = 0;
        for (int m = 0; m <= 300; m++) begin
            if (bus_a.timeout === 1'b1 && first_to < 0) first_to = m;
            if (first_to >= 0 && bus_a.timeout !== 1'b1) stuck_err++;
            exp = (m >= 1 && m <= FRAME) ? frame_level(d, m - 1) : 1'b1;
            if (bus_a.rx !== exp) wave_err++;
            if (m < 300) step();
        end
        n_tests += 4;
        if (first_to != 100)          begin n_fail++; $display("FAIL wd_rise: timeout rose %0d cycles after release want 100", first_to); end
        if (stuck_err != 0)           begin n_fail++; $display("FAIL wd_sticky: %0d cycles dropped want 0", stuck_err); end
        if (wave_err != 0)            begin n_fail++; $display("FAIL wd_frame: %0d wrong rx cycles want 0", wave_err); end
        if (bus_a.tx_count !== 32'd1) begin n_fail++; $display("FAIL wd_tx_count: got %0d want 1", bus_a.tx_count); end
    endtask

    // Random traffic on the instance with the watchdog disabled. The checker
    // enforces: a start bit appears exactly one cycle after an idle cycle in
    // which a byte is queued, never otherwise, and carries the oldest byte.
    task automatic test_random_nowd();
        r_seq_err = 0; r_wave_err = 0; r_to_err = 0; r_frames = 0;
        exp_q.delete();
        fork
            begin
                push_t e;
                for (int c = 0; c < 9000; c++) begin
                    bus_b.push_valid = ($urandom_range(0, 3) == 0);
                    bus_b.push_data  = 8'($urandom);
                    if (bus_b.push_valid && bus_b.push_ready) begin
                        e.d = bus_b.push_data;
                        e.acc = cyc + 1;
                        exp_q.push_back(e);
                    end
                    step();
                end
                bus_b.push_valid = 1'b0;
            end
            begin
                push_t e;
                int k;
                bit must;
                logic [7:0] cur;
                k = -1;
                must = 1'b0;
                cur = 8'h00;
                for (int s = 0; s < 12000; s++) begin
                    @(negedge clk);
                    if (bus_b.timeout !== 1'b0) r_to_err++;
                    if (k < 0) begin
                        if (bus_b.rx === 1'b0) begin
                            if (!must || exp_q.size() == 0) r_seq_err++;
                            else begin e = exp_q.pop_front(); cur = e.d; r_frames++; end
                            k = 1;
                            must = 1'b0;
                        end else begin
                            if (must) r_seq_err++;
                            must = (exp_q.size() > 0) && (exp_q[0].acc <= cyc);
                        end
                    end else begin
                        if (bus_b.rx !== frame_level(cur, k)) r_wave_err++;
                        k++;
                        if (k == FRAME) k = -1;
                    end
                end
            end
        join
        n_tests += 6;
        if (r_seq_err != 0)   begin n_fail++; $display("FAIL rnd_timing: %0d start-bit timing errors want 0", r_seq_err); end
        if (r_wave_err != 0)  begin n_fail++; $display("FAIL rnd_wave: %0d wrong rx cycles want 0", r_wave_err); end
        if (r_to_err != 0)    begin n_fail++; $display("FAIL rnd_timeout: timeout high on %0d cycles want 0", r_to_err); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d bytes never sent want 0", exp_q.size()); end
        if (bus_b.tx_count !== 32'(r_frames))
            begin n_fail++; $display("FAIL rnd_tx_count: got %0d want %0d", bus_b.tx_count, r_frames); end
        if (bus_b.busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy: got %b want 0", bus_b.busy); end
    endtask

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        bus_a.push_valid = 1'b0;
        bus_a.push_data  = 8'h00;
        bus_b.push_valid = 1'b0;
        bus_b.push_data  = 8'h00;
        test_reset();
        test_single_byte();
        test_mid_frame_reset();
        test_fifo_full();
        test_watchdog();
        test_random_nowd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1, "bench time limit reached");
    end

endmodule
